// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared constants and types for the 16-bit pipeline
//
// Purpose : data width, NOP encoding, fetch FSM state encoding, IF/ID field
//           layout used by decode, and the perf counter width.
// Ports   : none (package).
package pipeline_pkg;

   localparam int DATA_W = 16;
   localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0000;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_t;

   // IF/ID register layout when decode views it as one flat vector.
   localparam int IFID_INSTR_LSB = 0;
   localparam int IFID_PC_LSB    = DATA_W;
   localparam int IFID_PCP1_LSB  = 2 * DATA_W;
   localparam int IFID_VALID_BIT = 3 * DATA_W;
   localparam int IFID_W         = 3 * DATA_W + 1;

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] pcp1;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } ifid_t;

   localparam int PERF_CNT_W = 16;

endpackage

// File: rtl/fetch_perf_counters.sv
// rtl/fetch_perf_counters.sv - three saturating fetch-stage event counters
//
// Purpose : counts advance, stall and redirect (flush) cycles; each counter
//           sticks at all-ones instead of wrapping.
// Ports   : clk, rst_n (async, active-low)
//           fetch_ev, stall_ev, flush_ev   one-cycle event strobes
//           fetch_cnt, stall_cnt, flush_cnt   counter values
module fetch_perf_counters
   import pipeline_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fetch_ev,
   input  logic                  stall_ev,
   input  logic                  flush_ev,
   output logic [PERF_CNT_W-1:0] fetch_cnt,
   output logic [PERF_CNT_W-1:0] stall_cnt,
   output logic [PERF_CNT_W-1:0] flush_cnt
);

   logic [2:0]            ev;
   logic [PERF_CNT_W-1:0] cnt_q [3];

   assign ev = {flush_ev, stall_ev, fetch_ev};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (ev[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 1'b1;
         end
      end
   end

   assign fetch_cnt = cnt_q[0];
   assign stall_cnt = cnt_q[1];
   assign flush_cnt = cnt_q[2];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, run/halt FSM, IF/ID register
//
// Purpose : owns the PC, drives the combinational word-addressed instruction
//           memory and registers the returned word into IF/ID. Priority in
//           RUN is redirect > halt > stall > advance; HALT is left only by a
//           redirect or by reset.
// Ports   : CLK, RST_N (async, active-low)
//           stall_i, redirect_i, redirect_pc_i, halt_i   control from hazard/branch/decode
//           imem_addr_o, imem_rdata_i                    instruction memory
//           ifid_instr_o, ifid_pc_o, ifid_pcp1_o, ifid_valid_o   IF/ID register
//           halted_o                                     FSM is in HALT
//           perf_fetch_o, perf_stall_o, perf_flush_o     only with FETCH_PERF_CNT_EN
// Config  : FETCH_PERF_CNT_EN adds the saturating performance counters.
module fetch_stage
   import pipeline_pkg::*;
#(
   parameter int                DATA_W     = pipeline_pkg::DATA_W,
   parameter int                IMEM_DEPTH = 64,
   parameter logic [DATA_W-1:0] RESET_PC   = '0
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [DATA_W-1:0] redirect_pc_i,
   input  logic              halt_i,
   output logic [DATA_W-1:0] imem_addr_o,
   input  logic [DATA_W-1:0] imem_rdata_i,
   output logic [DATA_W-1:0] ifid_instr_o,
   output logic [DATA_W-1:0] ifid_pc_o,
   output logic [DATA_W-1:0] ifid_pcp1_o,
   output logic              ifid_valid_o,
`ifdef FETCH_PERF_CNT_EN
   output logic [PERF_CNT_W-1:0] perf_fetch_o,
   output logic [PERF_CNT_W-1:0] perf_stall_o,
   output logic [PERF_CNT_W-1:0] perf_flush_o,
`endif
   output logic              halted_o
);

   // The full PC goes out; the memory decodes only its low log2(IMEM_DEPTH)
   // bits, so this stage never range-checks the address.
   if (IMEM_DEPTH < 2 || IMEM_DEPTH > (2 ** DATA_W)) begin : g_bad_depth
      $error("fetch_stage: IMEM_DEPTH out of range for DATA_W");
   end

   localparam logic [DATA_W-1:0] NOP = DATA_W'(NOP_INSTR);
   localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

   fetch_state_t      state_q, state_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [DATA_W-1:0] ipc_q, ipc_d;
   logic [DATA_W-1:0] pcp1_q, pcp1_d;
   logic              valid_q, valid_d;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC;
         instr_q <= NOP;
         ipc_q   <= '0;
         pcp1_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         pcp1_q  <= pcp1_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      pcp1_d  = pcp1_q;
      valid_d = valid_q;
      case (state_q)
         ST_RUN: begin
            if (redirect_i) begin
               // Redirect wins over a simultaneous stall: the stalled slot
               // belongs to the wrong path anyway.
               pc_d    = redirect_pc_i;
               instr_d = NOP;
               valid_d = 1'b0;
            end else if (halt_i) begin
               state_d = ST_HALT;
               valid_d = 1'b0;
            end else if (!stall_i) begin
               instr_d = imem_rdata_i;
               ipc_d   = pc_q;
               pcp1_d  = pc_q + ONE;
               valid_d = 1'b1;
               pc_d    = pc_q + ONE;
            end
         end
         ST_HALT: begin
            valid_d = 1'b0;
            if (redirect_i) begin
               pc_d    = redirect_pc_i;
               instr_d = NOP;
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   assign imem_addr_o  = pc_q;
   assign ifid_instr_o = instr_q;
   assign ifid_pc_o    = ipc_q;
   assign ifid_pcp1_o  = pcp1_q;
   assign ifid_valid_o = valid_q;
   assign halted_o     = (state_q == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
   logic in_run;
   assign in_run = (state_q == ST_RUN);

   fetch_perf_counters u_perf (
      .clk       (CLK),
      .rst_n     (RST_N),
      .fetch_ev  (in_run && !redirect_i && !halt_i && !stall_i),
      .stall_ev  (in_run && !redirect_i && !halt_i &&  stall_i),
      .flush_ev  (in_run &&  redirect_i),
      .fetch_cnt (perf_fetch_o),
      .stall_cnt (perf_stall_o),
      .flush_cnt (perf_flush_o)
   );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage (FETCH_PERF_CNT_EN aware)
module tb_fetch_stage;
   import pipeline_pkg::*;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        stall, redirect, halt;
   logic [15:0] redirect_pc;
   logic [15:0] imem_addr, imem_rdata;
   logic [15:0] ifid_instr, ifid_pc, ifid_pcp1;
   logic        ifid_valid, halted;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] perf_fetch, perf_stall, perf_flush;
`endif

   logic [15:0] mem [64];
   assign imem_rdata = mem[imem_addr[5:0]];

   always #5 CLK = ~CLK;

   fetch_stage #(.DATA_W(16), .IMEM_DEPTH(64), .RESET_PC(16'h0000)) dut (
      .CLK           (CLK),
      .RST_N         (RST_N),
      .stall_i       (stall),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .halt_i        (halt),
      .imem_addr_o   (imem_addr),
      .imem_rdata_i  (imem_rdata),
      .ifid_instr_o  (ifid_instr),
      .ifid_pc_o     (ifid_pc),
      .ifid_pcp1_o   (ifid_pcp1),
      .ifid_valid_o  (ifid_valid),
`ifdef FETCH_PERF_CNT_EN
      .perf_fetch_o  (perf_fetch),
      .perf_stall_o  (perf_stall),
      .perf_flush_o  (perf_flush),
`endif
      .halted_o      (halted)
   );

   // Reference model: architectural view of the stage.
   logic [15:0] m_pc, m_instr, m_ipc, m_pcp1;
   logic        m_valid, m_halted;
   logic [15:0] m_nf, m_ns, m_nr;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   task automatic model_reset();
      m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000; m_pcp1 = 16'h0000;
      m_valid = 1'b0; m_halted = 1'b0;
      m_nf = 16'd0; m_ns = 16'd0; m_nr = 16'd0;
   endtask

   task automatic compare_all();
      check("imem_addr", imem_addr, m_pc);
      check("ifid_valid", ifid_valid, m_valid);
      check("halted", halted, m_halted);
      if (m_valid) begin
         check("ifid_instr", ifid_instr, m_instr);
         check("ifid_pc", ifid_pc, m_ipc);
         check("ifid_pcp1", ifid_pcp1, m_pcp1);
      end
`ifdef FETCH_PERF_CNT_EN
      check("perf_fetch", perf_fetch, m_nf);
      check("perf_stall", perf_stall, m_ns);
      check("perf_flush", perf_flush, m_nr);
`endif
   endtask

   // Drive one cycle of inputs (called between edges), advance the model at
   // the posedge, and compare just after it.
   task automatic step(input logic s, input logic r, input logic [15:0] t, input logic h);
      stall = s; redirect = r; redirect_pc = t; halt = h;
      @(posedge CLK);
      if (r) begin
         if (!m_halted) m_nr = sat_inc(m_nr);
         m_pc = t; m_valid = 1'b0; m_instr = 16'h0000; m_halted = 1'b0;
      end else if (m_halted) begin
         m_valid = 1'b0;
      end else if (h) begin
         m_halted = 1'b1; m_valid = 1'b0;
      end else if (s) begin
         m_ns = sat_inc(m_ns);
      end else begin
         m_instr = mem[m_pc[5:0]];
         m_ipc   = m_pc;
         m_pcp1  = m_pc + 16'd1;
         m_valid = 1'b1;
         m_pc    = m_pc + 16'd1;
         m_nf    = sat_inc(m_nf);
      end
      #1;
      compare_all();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_addr"}, imem_addr, 16'h0000);
      check({tag, "_instr"}, ifid_instr, 16'h0000);
      check({tag, "_pc"}, ifid_pc, 16'h0000);
      check({tag, "_pcp1"}, ifid_pcp1, 16'h0000);
      check({tag, "_valid"}, ifid_valid, 1'b0);
      check({tag, "_halted"}, halted, 1'b0);
`ifdef FETCH_PERF_CNT_EN
      check({tag, "_pf"}, perf_fetch, 16'd0);
      check({tag, "_ps"}, perf_stall, 16'd0);
      check({tag, "_pr"}, perf_flush, 16'd0);
`endif
   endtask

   // Pull reset low in the middle of a stalled cycle; outputs must clear
   // without waiting for a clock edge.
   task automatic async_reset_mid_stall(input string tag);
      stall = 1'b1; redirect = 1'b0; halt = 1'b0;
      @(posedge CLK);
      #2;
      RST_N = 1'b0;
      #1;
      check_reset_values(tag);
      model_reset();
      @(negedge CLK);
      RST_N = 1'b1;
      stall = 1'b0;
   endtask

   logic [15:0] abcd [4];

   initial begin
      stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = 16'h0000;
      for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
      abcd[0] = 16'hA1A1; abcd[1] = 16'hB2B2; abcd[2] = 16'hC3C3; abcd[3] = 16'hD4D4;
      for (int i = 0; i < 4; i++) mem[i] = abcd[i];
      model_reset();

      // 1: reset release and straight-line fetch of A,B,C,D
      #12;
      check_reset_values("rst0");
      @(negedge CLK);
      RST_N = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 16'h0, 1'b0);
         check("s1_instr", ifid_instr, abcd[i]);
         check("s1_pc", imem_addr, 16'(i + 1));
      end

      // 2: stall two cycles while IF/ID holds B
      async_reset_mid_stall("rst1");
      step(1'b0, 1'b0, 16'h0, 1'b0);
      step(1'b0, 1'b0, 16'h0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b0, 16'h0, 1'b0);
         check("s2_hold_instr", ifid_instr, abcd[1]);
         check("s2_hold_pc", ifid_pc, 16'd1);
      end
      step(1'b0, 1'b0, 16'h0, 1'b0);
      check("s2_instr", ifid_instr, abcd[2]);
      check("s2_pc", ifid_pc, 16'd2);

      // 3: redirect to 20 overrides a simultaneous stall
      step(1'b1, 1'b1, 16'd20, 1'b0);
      check("s3_valid", ifid_valid, 1'b0);
      check("s3_addr", imem_addr, 16'd20);
      step(1'b0, 1'b0, 16'h0, 1'b0);
      check("s3_ifid_pc", ifid_pc, 16'd20);
`ifdef FETCH_PERF_CNT_EN
      check("s3_perf_fetch", perf_fetch, 16'd4);
      check("s3_perf_stall", perf_stall, 16'd2);
      check("s3_perf_flush", perf_flush, 16'd1);
`endif

      // 6: reset mid-stall clears everything, counters included
      async_reset_mid_stall("rst2");

      // 4: halt at pc=5, stays frozen, redirect resumes
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
      step(1'b0, 1'b0, 16'h0, 1'b1);
      check("s4_halted", halted, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step(1'($urandom), 1'b0, 16'h0, 1'($urandom));
         check("s4_pc", imem_addr, 16'd5);
      end
      step(1'b0, 1'b1, 16'd0, 1'b0);
      check("s4_resume", halted, 1'b0);
      step(1'b0, 1'b0, 16'h0, 1'b0);

      // 5: PC wrap at 16'hFFFF
      step(1'b0, 1'b1, 16'hFFFF, 1'b0);
      step(1'b0, 1'b0, 16'h0, 1'b0);
      check("s5_ifid_pc", ifid_pc, 16'hFFFF);
      check("s5_pcp1", ifid_pcp1, 16'h0000);
      check("s5_addr", imem_addr, 16'h0000);
      step(1'b0, 1'b0, 16'h0, 1'b0);
      check("s5_ifid_pc2", ifid_pc, 16'h0000);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(3, 0) == 0),
              ($urandom_range(15, 0) == 0),
              16'($urandom),
              ($urandom_range(31, 0) == 0));
      end

      async_reset_mid_stall("rst3");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
